// File: rtl/spi_frame_master.sv
// SPI master for address+data write frames: 8-bit address byte, gap, Nbit word, MSB first.
// Optional miso capture into rdata is enabled by defining SPI_READBACK_EN.

module spi_frame_master #(
    parameter int Nbit      = 32,
    parameter int Dlitl     = 5,
    parameter int CS_LEAD   = 10,
    parameter int INTER_GAP = 1,
    parameter int CS_LAG    = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            wr,
    input  logic [6:0]      adr,
    input  logic [Nbit-1:0] data,
    output logic            busy,
    output logic            done,
    output logic            sclk,
    output logic            mosi,
    output logic            cs,
    input  logic            miso,
    output logic [Nbit-1:0] rdata
);
    localparam int DW = (2 * Dlitl > 1) ? $clog2(2 * Dlitl) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(2 * Dlitl - 1);
    localparam logic [DW-1:0] DIV_RISE = DW'(Dlitl - 1);
    localparam logic [DW-1:0] DIV_HI   = DW'(Dlitl);
    localparam logic [15:0] LEAD_LAST = 16'(CS_LEAD - 1);
    localparam logic [15:0] GAP_LAST  = 16'(INTER_GAP - 1);
    localparam logic [15:0] LAG_LAST  = 16'(CS_LAG - 1);
    localparam logic [15:0] ABIT_LAST = 16'd7;
    localparam logic [15:0] DBIT_LAST = 16'(Nbit - 1);

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        ADDR,
        GAP,
        DATA,
        CS_HOLD
    } state_t;

    state_t          r_state;
    logic [15:0]     r_cnt;
    logic [15:0]     r_bit;
    logic [DW-1:0]   r_div;
    logic [7:0]      r_adr_sr;
    logic [Nbit-1:0] r_dat_sr;
    logic            r_wr;
    logic            r_sclk;
    logic            r_mosi;
    logic            r_cs;
    logic            r_busy;
    logic            r_done;
    logic            w_bit_end;
    logic            w_rise;

`ifdef SPI_READBACK_EN
    logic [Nbit-1:0] r_cap;
    logic [Nbit-1:0] r_rdata;
    assign rdata = r_rdata;
`else
    logic w_unused_miso;
    assign w_unused_miso = miso;
    assign rdata = '0;
`endif

    assign w_bit_end = (r_div == DIV_LAST);
    assign w_rise    = (r_div == DIV_RISE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_div    <= '0;
            r_adr_sr <= '0;
            r_dat_sr <= '0;
            r_wr     <= 1'b0;
            r_sclk   <= 1'b0;
            r_mosi   <= 1'b1;
            r_cs     <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`ifdef SPI_READBACK_EN
            r_cap    <= '0;
            r_rdata  <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    // The done cycle is still IDLE; a start seen there is dropped.
                    if (start && !r_done) begin
                        r_adr_sr <= {wr, adr};
                        r_dat_sr <= data;
                        r_wr     <= wr;
                        r_cs     <= 1'b0;
                        r_busy   <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= CS_SETUP;
                    end
                end
                CS_SETUP: begin
                    if (r_cnt == LEAD_LAST) begin
                        r_state  <= ADDR;
                        r_mosi   <= r_adr_sr[7];
                        r_adr_sr <= {r_adr_sr[6:0], 1'b0};
                        r_div    <= '0;
                        r_bit    <= '0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ADDR: begin
                    if (w_bit_end) begin
                        r_sclk <= 1'b0;
                        r_div  <= '0;
                        if (r_bit == ABIT_LAST) begin
                            r_cnt <= '0;
                            if (INTER_GAP > 0) begin
                                r_state <= GAP;
                            end else begin
                                r_state  <= DATA;
                                r_mosi   <= r_wr ? r_dat_sr[Nbit-1] : 1'b1;
                                r_dat_sr <= {r_dat_sr[Nbit-2:0], 1'b0};
                                r_bit    <= '0;
                            end
                        end else begin
                            r_bit    <= r_bit + 16'd1;
                            r_mosi   <= r_adr_sr[7];
                            r_adr_sr <= {r_adr_sr[6:0], 1'b0};
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                        if (w_rise) r_sclk <= 1'b1;
                    end
                end
                GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_state  <= DATA;
                        r_mosi   <= r_wr ? r_dat_sr[Nbit-1] : 1'b1;
                        r_dat_sr <= {r_dat_sr[Nbit-2:0], 1'b0};
                        r_bit    <= '0;
                        r_div    <= '0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                DATA: begin
`ifdef SPI_READBACK_EN
                    if (r_sclk && r_div == DIV_HI)
                        r_cap <= {r_cap[Nbit-2:0], miso};
`endif
                    if (w_bit_end) begin
                        r_sclk <= 1'b0;
                        r_div  <= '0;
                        if (r_bit == DBIT_LAST) begin
                            r_state <= CS_HOLD;
                            r_mosi  <= 1'b1;
                            r_cnt   <= '0;
                        end else begin
                            r_bit    <= r_bit + 16'd1;
                            r_mosi   <= r_wr ? r_dat_sr[Nbit-1] : 1'b1;
                            r_dat_sr <= {r_dat_sr[Nbit-2:0], 1'b0};
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                        if (w_rise) r_sclk <= 1'b1;
                    end
                end
                CS_HOLD: begin
                    if (r_cnt == LAG_LAST) begin
                        r_cs    <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
`ifdef SPI_READBACK_EN
                        r_rdata <= r_cap;
`endif
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sclk = r_sclk;
    assign mosi = r_mosi;
    assign cs   = r_cs;

endmodule

// File: tb/tb_spi_frame_master.sv
// Scoreboard bench for spi_frame_master: one instance at Dlitl=5, one at Dlitl=1,
// each with a monitor that rebuilds the frame and a miso slave model.

module tb_spi_frame_master;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr;
    logic [6:0]  adr;
    logic [31:0] data;
    logic        start [2];
    logic        busy  [2];
    logic        done  [2];
    logic        sclk  [2];
    logic        mosi  [2];
    logic        cs    [2];
    logic [31:0] rdata [2];
    logic [31:0] slv_word = 32'hA5A5_0F0F;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [39:0] bits;
        int          cslow;
        int          rises;
        logic [31:0] rd;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    for (genvar k = 0; k < 2; k++) begin : g
        localparam int D = (k == 0) ? 5 : 1;
        logic        miso = 1'b1;
        int          cslow_c = 0;
        int          rise_c = 0;
        int          n_done = 0;
        logic [39:0] sh = '0;
        logic        psclk = 1'b0;
        logic        pdone = 1'b0;
        exp_t        e;

        spi_frame_master #(
            .Nbit(32), .Dlitl(D), .CS_LEAD(10), .INTER_GAP(1), .CS_LAG(10)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .start(start[k]), .wr(wr), .adr(adr),
            .data(data), .busy(busy[k]), .done(done[k]), .sclk(sclk[k]),
            .mosi(mosi[k]), .cs(cs[k]), .miso(miso), .rdata(rdata[k])
        );

        always @(negedge clk) begin
            if (!rst_n) begin
                cslow_c = 0;
                rise_c  = 0;
                sh      = '0;
                psclk   = 1'b0;
                pdone   = 1'b0;
                miso    = 1'b1;
            end else begin
                if (!cs[k]) cslow_c++;
                if (cs[k] && sclk[k])
                    check($sformatf("k%0d_sclk_while_cs_high", k), 1, 0);
                if (sclk[k] && !psclk) begin
                    rise_c++;
                    sh = {sh[38:0], mosi[k]};
                end
                if (psclk && !sclk[k])
                    miso = (rise_c >= 8 && rise_c < 40) ? slv_word[39-rise_c] : 1'b1;
                if (done[k]) begin
                    n_done++;
                    if (pdone) check($sformatf("k%0d_done_width", k), 1, 0);
                    if ((k == 0 ? q0.size() : q1.size()) == 0) begin
                        check($sformatf("k%0d_unexpected_done", k), 1, 0);
                    end else begin
                        e = (k == 0) ? q0.pop_front() : q1.pop_front();
                        check($sformatf("k%0d_bits", k), 64'(sh), 64'(e.bits));
                        check($sformatf("k%0d_cs_low", k), 64'(cslow_c), 64'(e.cslow));
                        check($sformatf("k%0d_rises", k), 64'(rise_c), 64'(e.rises));
                        check($sformatf("k%0d_rdata", k), 64'(rdata[k]), 64'(e.rd));
                    end
                    cslow_c = 0;
                    rise_c  = 0;
                    sh      = '0;
                    miso    = 1'b1;
                end
                psclk = sclk[k];
                pdone = done[k];
            end
        end
    end

    function automatic void push(input int k, input logic w,
                                 input logic [6:0] a, input logic [31:0] d);
        exp_t x;
        int   dl;
        dl      = (k == 0) ? 5 : 1;
        x.bits  = {w, a, (w ? d : 32'hFFFF_FFFF)};
        x.cslow = 10 + 16 * dl + 1 + 64 * dl + 10;
        x.rises = 40;
`ifdef SPI_READBACK_EN
        x.rd    = slv_word;
`else
        x.rd    = '0;
`endif
        if (k == 0) q0.push_back(x);
        else q1.push_back(x);
    endfunction

    task automatic drive(input int k, input logic w, input logic [6:0] a,
                         input logic [31:0] d);
        @(posedge clk) #1;
        wr       = w;
        adr      = a;
        data     = d;
        start[k] = 1'b1;
        @(posedge clk) #1;
        start[k] = 1'b0;
        check($sformatf("k%0d_accept_busy", k), 64'(busy[k]), 1);
    endtask

    task automatic send(input int k, input logic w, input logic [6:0] a,
                        input logic [31:0] d);
        push(k, w, a, d);
        drive(k, w, a, d);
    endtask

    task automatic wait_idle(input int k);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk) #1;
            if (!busy[k]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check($sformatf("k%0d_idle_timeout", k), 1, 0);
        @(posedge clk) #1;
    endtask

    task automatic check_idle_pins(input int k, input string tag);
        check({tag, "_cs"}, 64'(cs[k]), 1);
        check({tag, "_sclk"}, 64'(sclk[k]), 0);
        check({tag, "_mosi"}, 64'(mosi[k]), 1);
        check({tag, "_busy"}, 64'(busy[k]), 0);
        check({tag, "_done"}, 64'(done[k]), 0);
    endtask

    initial begin
        int gap;
        int dn;
        rst_n    = 1'b0;
        start[0] = 1'b0;
        start[1] = 1'b0;
        wr       = 1'b0;
        adr      = '0;
        data     = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_pins(0, "rst0");
        check_idle_pins(1, "rst1");
        check("rst_rdata", 64'(rdata[0]), 0);
        rst_n = 1'b1;

        send(0, 1'b1, 7'd1, 32'hDEED_BEEF);
        wait_idle(0);
        send(0, 1'b0, 7'd5, 32'h1234_5678);
        wait_idle(0);

        dn = g[0].n_done;
        send(0, 1'b1, 7'h2A, 32'h0F0F_1234);
        repeat (48) @(posedge clk);
        #1;
        start[0] = 1'b1;
        data     = 32'h5555_AAAA;
        @(posedge clk) #1;
        start[0] = 1'b0;
        wait_idle(0);
        repeat (5) @(posedge clk);
        #1;
        check("ignored_start_busy", 64'(busy[0]), 0);
        check("ignored_start_dones", 64'(g[0].n_done - dn), 1);

        push(0, 1'b1, 7'h11, 32'h8000_0001);
        push(0, 1'b1, 7'h22, 32'h7FFF_FFFE);
        @(posedge clk) #1;
        wr       = 1'b1;
        adr      = 7'h11;
        data     = 32'h8000_0001;
        start[0] = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk) #1;
            if (done[0]) break;
        end
        check("b2b_first_done", 64'(done[0]), 1);
        adr  = 7'h22;
        data = 32'h7FFF_FFFE;
        gap  = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk) #1;
            gap++;
            if (!cs[0]) break;
        end
        start[0] = 1'b0;
        check("b2b_cs_fall_gap", 64'(gap), 2);
        wait_idle(0);

        drive(0, 1'b1, 7'h33, 32'h0000_0000);
        repeat (198) @(posedge clk);
        #1;
        check("pre_rst_sclk", 64'(sclk[0]), 1);
        check("pre_rst_mosi", 64'(mosi[0]), 0);
        rst_n = 1'b0;
        #1;
        check_idle_pins(0, "midrst");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        send(0, 1'b1, 7'h03, 32'hCAFE_F00D);
        wait_idle(0);

        send(1, 1'b1, 7'd1, 32'hDEED_BEEF);
        wait_idle(1);
        send(1, 1'b0, 7'h7F, 32'h0000_0000);
        wait_idle(1);

        repeat (5) @(posedge clk);
        #1;
        check("sb0_empty", 64'(q0.size()), 0);
        check("sb1_empty", 64'(q1.size()), 0);
        check("k0_done_total", 64'(g[0].n_done), 6);
        check("k1_done_total", 64'(g[1].n_done), 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=1 want=0");
        $fatal(1, "timeout");
    end

endmodule
